angle_reduce: RTL and testbench

ANGLE_REDUCE -- requirements
Module: angle_reduce

---
 rtl/angle_reduce_pkg.sv | 21 ++
 rtl/angle_reduce_fix2float.sv | 26 ++
 rtl/angle_reduce.sv | 121 ++++++++++++
 tb/tb_angle_reduce.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/angle_reduce_pkg.sv
// Shared constants and types for the angle range-reduction block.
// The datapath is unsigned Q8.24; the results are IEEE-754 single precision.
package angle_reduce_pkg;

  localparam logic [31:0] TWO_PI_Q = 32'h0648_7ED5;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  localparam int EXP_BIAS = 127;
  localparam int FRAC_W   = 23;
  localparam int FIX_FRAC = 24;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CONVERT   = 3'd1,
    REDUCE    = 3'd2,
    ADJUST    = 3'd3,
    NORMALIZE = 3'd4,
    DONE      = 3'd5
  } state_t;

endpackage

// File: rtl/angle_reduce_fix2float.sv
// Combinational normalizer from unsigned Q8.24 to a positive IEEE-754 single.
// The mantissa is truncated, and zero maps to +0.0.
module fix2float
  import angle_reduce_pkg::*;
(
  input  logic [31:0] fix,
  output logic [31:0] flt
);

  logic [4:0]  msb;
  logic [31:0] norm;
  logic [7:0]  exp_f;

  always_comb begin
    msb = '0;
    for (int i = 0; i < 32; i++) begin
      if (fix[i]) msb = 5'(i);
    end
    // The leading one moves to bit 31, so the fraction sits directly below it
    norm  = fix << (5'd31 - msb);
    exp_f = 8'(EXP_BIAS - FIX_FRAC) + {3'b000, msb};
    if (fix == 32'h0) flt = 32'h0;
    else              flt = {1'b0, exp_f, norm[30 -: FRAC_W]};
  end

endmodule

// File: rtl/angle_reduce.sv
// Reduces a single-precision angle to [0, 2pi) with fixed latency, using
// shift-subtract modulo iterations on a Q8.24 magnitude.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | wait for reduce_start; latch angle on acceptance
// CONVERT   | float -> Q8.24 magnitude; range/NaN check (error -> DONE)
// REDUCE    | REDUCE_STEPS conditional subtracts of TWO_PI_Q << k
// ADJUST    | mirror the remainder for negative inputs
// NORMALIZE | Q8.24 remainder -> float, captured into the result register
// DONE      | one-cycle reduce_done pulse
module angle_reduce
  import angle_reduce_pkg::*;
#(
  parameter int REDUCE_STEPS = 6
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        reduce_start,
  input  logic [31:0] angle,
  output logic        busy,
  output logic        reduce_done,
  output logic [31:0] reduced_angle,
  output logic        reduce_error
);

  localparam int CNT_W = (REDUCE_STEPS > 1) ? $clog2(REDUCE_STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(REDUCE_STEPS - 1);
  localparam logic [7:0]       SHIFT_REF = 8'(EXP_BIAS + FRAC_W - FIX_FRAC);
  localparam logic [7:0]       EXP_LIMIT = 8'(EXP_BIAS + 32 - FIX_FRAC);

  state_t           state_q, state_d;
  logic [31:0]      angle_q;
  logic [31:0]      rem_q;
  logic [31:0]      result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic [7:0]  in_exp;
  logic [31:0] in_mant;
  logic [31:0] conv_mag;
  logic        conv_err;
  logic [32:0] step_val;
  logic        step_ge;
  logic [31:0] norm_flt;

  fix2float u_fix2float (
    .fix (rem_q),
    .flt (norm_flt)
  );

  always_comb begin
    in_exp   = angle_q[30:23];
    in_mant  = {8'h00, 1'b1, angle_q[22:0]};
    conv_err = (in_exp == 8'hFF) || (in_exp >= EXP_LIMIT);
    conv_mag = '0;
    if (in_exp == 8'h00)          conv_mag = '0;
    else if (in_exp >= SHIFT_REF) conv_mag = in_mant << (in_exp - SHIFT_REF);
    else                          conv_mag = in_mant >> (SHIFT_REF - in_exp);
  end

  always_comb begin
    step_val = {1'b0, TWO_PI_Q} << cnt_q;
    step_ge  = {1'b0, rem_q} >= step_val;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (reduce_start) state_d = CONVERT;
      CONVERT:   state_d = conv_err ? DONE : REDUCE;
      REDUCE:    if (cnt_q == '0) state_d = ADJUST;
      ADJUST:    state_d = NORMALIZE;
      NORMALIZE: state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != IDLE);
    reduce_done  = (state_q == DONE);
    reduce_error = (state_q == DONE) && err_q;
  end

  // result_q is written only on the two transitions into DONE
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      angle_q  <= '0;
      rem_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (reduce_start) angle_q <= angle;
        CONVERT: begin
          rem_q <= conv_mag;
          err_q <= conv_err;
          cnt_q <= CNT_LOAD;
          if (conv_err) result_q <= QNAN;
        end
        REDUCE: begin
          if (step_ge) rem_q <= rem_q - step_val[31:0];
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        ADJUST: if (angle_q[31] && (rem_q != '0)) rem_q <= TWO_PI_Q - rem_q;
        NORMALIZE: result_q <= norm_flt;
        default: ;
      endcase
    end
  end

  assign reduced_angle = result_q;

endmodule

// File: tb/tb_angle_reduce.sv
// Self-checking bench for angle_reduce: directed corner angles, random angles
// against an arithmetic model, start/reset interference scenarios.
module tb_angle_reduce;

  localparam longint TWO_PI_INT = 64'd105414357;
  localparam real    TWO_PI_R   = 6.283185307179586;
  localparam real    TOL        = 3.814697265625e-6;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        reduce_start = 1'b0;
  logic [31:0] angle = '0;
  logic        busy;
  logic        reduce_done;
  logic [31:0] reduced_angle;
  logic        reduce_error;

  int n_chk  = 0;
  int n_pass = 0;

  angle_reduce #(.REDUCE_STEPS(6)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .reduce_start  (reduce_start),
    .angle         (angle),
    .busy          (busy),
    .reduce_done   (reduce_done),
    .reduced_angle (reduced_angle),
    .reduce_error  (reduce_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  function automatic real f2r(input logic [31:0] b);
    int  e;
    real v;
    e = int'(b[30:23]);
    if (e == 0) v = 0.0;
    else v = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return b[31] ? -v : v;
  endfunction

  // Exact result: truncated Q8.24 magnitude, integer modulo, sign mirror,
  // then a truncating float encode.
  function automatic void model(input logic [31:0] a, output logic [31:0] res, output bit err);
    real    mag;
    longint m, r;
    int     p;
    longint mant;
    err = 1'b0;
    res = 32'h0;
    if (a[30:23] == 8'hFF) begin
      err = 1'b1;
      res = 32'h7FC0_0000;
      return;
    end
    mag = f2r({1'b0, a[30:0]});
    if (mag >= 256.0) begin
      err = 1'b1;
      res = 32'h7FC0_0000;
      return;
    end
    m = longint'($floor(mag * 16777216.0));
    r = m % TWO_PI_INT;
    if (a[31] && r != 0) r = TWO_PI_INT - r;
    if (r == 0) return;
    p = 0;
    while ((r >> (p + 1)) != 0) p++;
    mant = ((r << 23) >> p) & 64'h7F_FFFF;
    res = {1'b0, 8'(127 + p - 24), mant[22:0]};
  endfunction

  // Drives a start and waits for reduce_done; returns in the DONE cycle.
  // poke_at > 0 pulses a second start (angle b) that must be ignored.
  task automatic run_one(input string tag, input logic [31:0] a, input int poke_at,
                         input logic [31:0] b, output bit seen);
    logic [31:0] expv;
    bit          err;
    int          lat;
    real         tv, dv, d;
    model(a, expv, err);
    seen = 1'b0;
    lat  = 0;
    reduce_start = 1'b1;
    angle = a;
    @(posedge clk);
    #1;
    reduce_start = 1'b0;
    angle = $urandom;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    for (int i = 1; i <= 20; i++) begin
      if (i == poke_at) begin
        reduce_start = 1'b1;
        angle = b;
      end
      @(posedge clk);
      #1;
      reduce_start = 1'b0;
      if (reduce_done) begin
        lat  = i;
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_seen"}, 64'(seen), 64'd1);
    if (!seen) return;
    if (!err) chk({tag, "_lat"}, 64'(lat), 64'd9);
    chk({tag, "_val"}, 64'(reduced_angle), 64'(expv));
    chk({tag, "_err"}, 64'(reduce_error), 64'(err));
    if (!err) begin
      tv = f2r(a);
      tv = tv - TWO_PI_R * $floor(tv / TWO_PI_R);
      dv = f2r(reduced_angle);
      d  = (dv > tv) ? dv - tv : tv - dv;
      if (TWO_PI_R - d < d) d = TWO_PI_R - d;
      chk({tag, "_tol"}, 64'(d <= TOL), 64'd1);
    end
  endtask

  task automatic after_done(input string tag, input logic [31:0] held);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 64'({reduce_done, busy, reduce_error}), 64'd0);
    chk({tag, "_hold"}, 64'(reduced_angle), 64'(held));
  endtask

  logic [31:0] dir_tab [14] = '{
    32'h3FC9_0FDB,  // pi/2
    32'h412F_EDDF,  // 7pi/2
    32'hBFC9_0FDB,  // -pi/2
    32'h40C9_0FDB,  // 2pi as a float, 3 LSBs above TWO_PI_Q -> tiny residue
    32'h7FC0_0000,  // NaN
    32'h4396_0000,  // 300.0
    32'h0000_0000,
    32'h8000_0000,  // -0.0
    32'hC380_0000,  // -256.0
    32'h437F_FFFF,  // just below 256
    32'h7F80_0000,  // +Inf
    32'h0000_0001,  // denormal
    32'h8000_0001,  // negative denormal
    32'hC2C8_0000   // -100.0
  };

  initial begin
    bit          seen;
    logic [31:0] a, held;
    int          extra;

    #2;
    chk("rst_out", 64'({busy, reduce_done, reduce_error, reduced_angle}), 64'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;

    foreach (dir_tab[i]) begin
      run_one($sformatf("dir%0d", i), dir_tab[i], 0, 32'h0, seen);
      held = reduced_angle;
      if (seen) after_done($sformatf("dir%0d", i), held);
    end

    for (int i = 0; i < 40; i++) begin
      logic [7:0] e;
      e = 8'($urandom_range(110, 136));
      if ($urandom_range(0, 9) == 0) e = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
      a = {1'($urandom_range(0, 1)), e, 23'($urandom)};
      run_one($sformatf("rnd%0d", i), a, 0, 32'h0, seen);
      held = reduced_angle;
      if (seen) after_done($sformatf("rnd%0d", i), held);
    end

    // second start during REDUCE must not disturb the first result
    run_one("poke", 32'h4120_0000, 4, 32'hC2C8_0000, seen);
    extra = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      if (reduce_done) extra++;
    end
    chk("poke_single", 64'(extra), 64'd0);

    // start held in the DONE cycle is ignored
    run_one("indone", 32'h4049_0FDB, 0, 32'h0, seen);
    reduce_start = 1'b1;
    angle = 32'h3F80_0000;
    @(posedge clk);
    #1;
    reduce_start = 1'b0;
    chk("indone_idle", 64'(busy), 64'd0);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (reduce_done || busy) extra++;
    end
    chk("indone_quiet", 64'(extra), 64'd0);

    // reset in the middle of REDUCE abandons the computation
    reduce_start = 1'b1;
    angle = 32'h42F0_0000;
    @(posedge clk);
    #1;
    reduce_start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_out", 64'({busy, reduce_done, reduce_error, reduced_angle}), 64'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (reduce_done) extra++;
    end
    chk("mid_rst_nodone", 64'(extra), 64'd0);
    run_one("post_rst", 32'hC0A0_0000, 0, 32'h0, seen);
    held = reduced_angle;
    if (seen) after_done("post_rst", held);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
